// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: IR, FETCH/DECODE/EXEC/MEM/WB sequencing, memory timeouts.
// Optional RV32M dispatch to an external MDU when CTRL_MULDIV_EN is defined.
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned WAIT_W      = 5,
    parameter int unsigned CNT_W       = 32,
    parameter logic [31:0] IR_RESET    = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_instr,
    input  logic             i_imem_ack,
    output logic             o_imem_req,
    input  logic             i_dmem_ack,
    output logic             o_dmem_req,
    output logic             o_mem_wren,
    input  logic             i_brc_less,
    input  logic             i_brc_equal,
    output logic             o_pc_en,
    output logic             o_pc_sel,
    output logic             o_rd_wren,
    output logic             o_insn_vld,
    output logic             o_br_un,
    output logic             o_opa_sel,
    output logic             o_opb_sel,
    output logic [1:0]       o_wb_sel,
    output logic [3:0]       o_alu_op,
    output logic [31:0]      o_ir,
`ifdef CTRL_MULDIV_EN
    output logic             o_mdu_start,
    output logic [2:0]       o_mdu_op,
    input  logic             i_mdu_done,
`endif
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_load, is_store, is_branch, is_jal, is_jalr;
    logic is_opimm, is_op, is_lui, is_auipc, is_fence, is_mdu;
    logic legal, br_taken;
    logic imem_req, dmem_req, pc_en, pc_sel, rd_wren, vld;

    assign opc = ir_q[6:2];
    assign f3  = ir_q[14:12];
    assign f7  = ir_q[31:25];

    assign is_load   = (opc == 5'b00000);
    assign is_fence  = (opc == 5'b00011);
    assign is_opimm  = (opc == 5'b00100);
    assign is_auipc  = (opc == 5'b00101);
    assign is_store  = (opc == 5'b01000);
    assign is_op     = (opc == 5'b01100);
    assign is_lui    = (opc == 5'b01101);
    assign is_branch = (opc == 5'b11000);
    assign is_jalr   = (opc == 5'b11001);
    assign is_jal    = (opc == 5'b11011);
`ifdef CTRL_MULDIV_EN
    assign is_mdu    = is_op && (f7 == 7'h01);
`else
    assign is_mdu    = 1'b0;
`endif

    // Branch outcome: bit2 selects less/equal, bit0 inverts the sense
    assign br_taken = f3[2] ? (i_brc_less ^ f3[0]) : (i_brc_equal ^ f3[0]);

    // Legality check and datapath selects, decoded from the latched IR
    always_comb begin
        legal     = 1'b0;
        o_alu_op  = 4'd0;
        o_opa_sel = 1'b0;
        o_opb_sel = 1'b0;
        o_wb_sel  = 2'b01;
        o_br_un   = 1'b0;
        unique case (1'b1)
            is_load: begin
                legal     = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                o_opb_sel = 1'b1;
                o_wb_sel  = 2'b10;
            end
            is_store: begin
                legal     = (f3 <= 3'd2);
                o_opb_sel = 1'b1;
            end
            is_branch: begin
                legal     = (f3 != 3'd2) && (f3 != 3'd3);
                o_opa_sel = 1'b1;
                o_opb_sel = 1'b1;
                o_br_un   = f3[2] & f3[1];
            end
            is_jal: begin
                legal     = 1'b1;
                o_opa_sel = 1'b1;
                o_opb_sel = 1'b1;
                o_wb_sel  = 2'b00;
            end
            is_jalr: begin
                legal     = (f3 == 3'd0);
                o_opb_sel = 1'b1;
                o_wb_sel  = 2'b00;
            end
            is_lui: begin
                legal     = 1'b1;
                o_opb_sel = 1'b1;
                o_alu_op  = 4'd10;
            end
            is_auipc: begin
                legal     = 1'b1;
                o_opa_sel = 1'b1;
                o_opb_sel = 1'b1;
            end
            is_fence: begin
                legal     = (f3 == 3'd0);
            end
            is_opimm: begin
                if (f3 == 3'd1)
                    legal = (f7 == 7'h00);
                else if (f3 == 3'd5)
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                else
                    legal = 1'b1;
                o_opb_sel = 1'b1;
                o_alu_op  = alu_f3(f3, 1'b0, f7[5]);
            end
            is_op: begin
                legal    = (f7 == 7'h00) || is_mdu ||
                           ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                o_alu_op = alu_f3(f3, 1'b1, f7[5]);
                if (is_mdu)
                    o_wb_sel = 2'b11;
            end
            default: legal = 1'b0;
        endcase
        if (ir_q[1:0] != 2'b11)
            legal = 1'b0;
    end

    function automatic logic [3:0] alu_f3(input logic [2:0] f, input logic rr, input logic b30);
        logic [3:0] r;
        r = 4'd0;
        case (f)
            3'd0: r = (rr && b30) ? 4'd1 : 4'd0;
            3'd1: r = 4'd2;
            3'd2: r = 4'd3;
            3'd3: r = 4'd4;
            3'd4: r = 4'd5;
            3'd5: r = b30 ? 4'd7 : 4'd6;
            3'd6: r = 4'd8;
            default: r = 4'd9;
        endcase
        return r;
    endfunction

`ifdef CTRL_MULDIV_EN
    logic busy_q, busy_d;
    logic mdu_start;
`endif

    // Sequencer: next state, IR capture, wait counter and strobes
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        wait_d   = wait_q;
        cause_d  = cause_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = 1'b0;
        rd_wren  = 1'b0;
        vld      = 1'b0;
`ifdef CTRL_MULDIV_EN
        busy_d    = busy_q;
        mdu_start = 1'b0;
`endif
        unique case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (i_imem_ack) begin
                    ir_d    = i_instr;
                    state_d = S_DECODE;
                end else if (wait_q == TMO) begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd0;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    pc_en   = 1'b1;
                    pc_sel  = br_taken;
                    vld     = 1'b1;
                    state_d = S_FETCH;
                    wait_d  = '0;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end else if (is_mdu) begin
`ifdef CTRL_MULDIV_EN
                    mdu_start = ~busy_q;
                    busy_d    = 1'b1;
                    if (i_mdu_done) begin
                        busy_d  = 1'b0;
                        state_d = S_WB;
                    end
`else
                    state_d = S_WB;
`endif
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (i_dmem_ack) begin
                    if (is_store) begin
                        pc_en   = 1'b1;
                        vld     = 1'b1;
                        state_d = S_FETCH;
                        wait_d  = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == TMO) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB: begin
                rd_wren = 1'b1;
                pc_en   = 1'b1;
                pc_sel  = is_jal | is_jalr;
                vld     = 1'b1;
                state_d = S_FETCH;
                wait_d  = '0;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        instret_d = vld ? instret_q + CNT_W'(1) : instret_q;
    end

    // State registers; reset aborts any transaction in flight
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            ir_q      <= IR_RESET;
            wait_q    <= '0;
            cause_q   <= 2'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

`ifdef CTRL_MULDIV_EN
    // Remembers that the MDU was started so start is a single pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            busy_q <= 1'b0;
        else
            busy_q <= busy_d;
    end

    assign o_mdu_start = mdu_start & ~i_rst;
    assign o_mdu_op    = f3;
`endif

    assign o_imem_req   = imem_req & ~i_rst;
    assign o_dmem_req   = dmem_req & ~i_rst;
    assign o_mem_wren   = dmem_req & is_store & ~i_rst;
    assign o_pc_en      = pc_en & ~i_rst;
    assign o_pc_sel     = pc_sel & ~i_rst;
    assign o_rd_wren    = rd_wren & ~i_rst;
    assign o_insn_vld   = vld & ~i_rst;
    assign o_ir         = ir_q;
    assign o_trap       = (state_q == S_TRAP);
    assign o_trap_cause = cause_q;
    assign o_instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ack, dmem_ack, less, equal;
    logic        imem_req, dmem_req, mem_wren, pc_en, pc_sel, rd_wren;
    logic        insn_vld, br_un, opa_sel, opb_sel, trap;
    logic [1:0]  wb_sel, cause;
    logic [3:0]  alu_op;
    logic [31:0] ir, instret;
`ifdef CTRL_MULDIV_EN
    logic        mdu_start, mdu_done;
    logic [2:0]  mdu_op;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cnt;

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] BGEU = 32'h0020_F063;
    localparam logic [31:0] LW   = 32'h0000_A183;
    localparam logic [31:0] SW   = 32'h0020_A023;
    localparam logic [31:0] SUB  = 32'h4031_00B3;
    localparam logic [31:0] JAL  = 32'h0000_00EF;
    localparam logic [31:0] MUL  = 32'h0231_00B3;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr),
        .i_imem_ack(imem_ack), .o_imem_req(imem_req),
        .i_dmem_ack(dmem_ack), .o_dmem_req(dmem_req),
        .o_mem_wren(mem_wren), .i_brc_less(less),
        .i_brc_equal(equal), .o_pc_en(pc_en),
        .o_pc_sel(pc_sel), .o_rd_wren(rd_wren),
        .o_insn_vld(insn_vld), .o_br_un(br_un),
        .o_opa_sel(opa_sel), .o_opb_sel(opb_sel),
        .o_wb_sel(wb_sel), .o_alu_op(alu_op), .o_ir(ir),
`ifdef CTRL_MULDIV_EN
        .o_mdu_start(mdu_start), .o_mdu_op(mdu_op),
        .i_mdu_done(mdu_done),
`endif
        .o_trap(trap), .o_trap_cause(cause),
        .o_instret(instret)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called in FETCH; returns at the first DECODE sample
    task automatic fetch(input logic [31:0] ins, input int dly);
        repeat (dly) step();
        instr    = ins;
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; instr = '0; imem_ack = 0; dmem_ack = 0;
        less = 0; equal = 0;
`ifdef CTRL_MULDIV_EN
        mdu_done = 0;
`endif
        step();
        step();
        check("rst_imem_req", imem_req, 0);
        check("rst_pc_en", pc_en, 0);
        check("rst_rd_wren", rd_wren, 0);
        check("rst_vld", insn_vld, 0);
        check("rst_ir", ir, 32'h13);
        check("rst_alu_op", alu_op, 0);
        check("rst_opb_sel", opb_sel, 1);
        check("rst_wb_sel", wb_sel, 1);
        check("rst_instret", instret, 0);
        check("rst_trap", trap, 0);
        rst = 1'b0;
        #1 check("fetch_req", imem_req, 1);

        fetch(ADDI, 1);
        check("addi_ir", ir, ADDI);
        check("addi_dec_req", imem_req, 0);
        step();
        check("addi_ex_wren", rd_wren, 0);
        check("addi_alu_op", alu_op, 0);
        check("addi_opb", opb_sel, 1);
        step();
        check("addi_wb_wren", rd_wren, 1);
        check("addi_wb_pcen", pc_en, 1);
        check("addi_wb_pcsel", pc_sel, 0);
        check("addi_wb_sel", wb_sel, 1);
        step();
        check("addi_fetch_wren", rd_wren, 0);
        check("addi_instret", instret, 1);

        fetch(BGEU, 0);
        check("bgeu_dec_pcen", pc_en, 0);
        step();
        check("bgeu_pcen", pc_en, 1);
        check("bgeu_vld", insn_vld, 1);
        check("bgeu_taken", pc_sel, 1);
        check("bgeu_un", br_un, 1);
        step();
        check("bgeu_back_req", imem_req, 1);
        check("bgeu_instret", instret, 2);

        fetch(BGEU, 0);
        less = 1'b1;
        step();
        check("bgeu_nt_pcen", pc_en, 1);
        check("bgeu_nt_sel", pc_sel, 0);
        step();
        less = 1'b0;
        check("bgeu_nt_instret", instret, 3);

        fetch(LW, 0);
        step();
        check("lw_ex_dreq", dmem_req, 0);
        step();
        check("lw_wren", mem_wren, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (dmem_req) cnt++;
            if (i == 3) dmem_ack = 1'b1;
            step();
        end
        dmem_ack = 1'b0;
        check("lw_req_cycles", cnt, 4);
        check("lw_wb_sel", wb_sel, 2);
        check("lw_wb_wren", rd_wren, 1);
        check("lw_wb_dreq", dmem_req, 0);
        step();
        check("lw_instret", instret, 4);

        fetch(SW, 0);
        step();
        step();
        check("sw_dreq", dmem_req, 1);
        check("sw_wren", mem_wren, 1);
        dmem_ack = 1'b1;
        #1;
        check("sw_pcen", pc_en, 1);
        check("sw_vld", insn_vld, 1);
        check("sw_rdwren", rd_wren, 0);
        step();
        dmem_ack = 1'b0;
        check("sw_next_rdwren", rd_wren, 0);
        check("sw_instret", instret, 5);

        fetch(SUB, 0);
        step();
        check("sub_alu_op", alu_op, 1);
        check("sub_opb", opb_sel, 0);
        step();
        check("sub_wb_wren", rd_wren, 1);
        step();

        fetch(JAL, 0);
        step();
        check("jal_ex_pcen", pc_en, 0);
        step();
        check("jal_wb_pcen", pc_en, 1);
        check("jal_wb_pcsel", pc_sel, 1);
        check("jal_wb_sel", wb_sel, 0);
        check("jal_opa", opa_sel, 1);
        step();
        check("jal_instret", instret, 7);

        repeat (16) step();
        check("tmo_edge_req", imem_req, 1);
        fetch(ADDI, 0);
        check("tmo_edge_trap", trap, 0);
        check("tmo_edge_dec", imem_req, 0);
        repeat (3) step();
        check("tmo_edge_instret", instret, 8);

        repeat (16) step();
        check("tmo_pre_trap", trap, 0);
        check("tmo_pre_req", imem_req, 1);
        step();
        check("tmo_trap", trap, 1);
        check("tmo_cause", cause, 1);
        check("tmo_req_drop", imem_req, 0);

        do_reset();
        check("rst2_trap", trap, 0);
        check("rst2_cause", cause, 0);
        fetch(32'hFFFF_FFFF, 0);
        step();
        check("ill_trap", trap, 1);
        check("ill_cause", cause, 0);
        step();
        check("ill_hold", trap, 1);
        check("ill_no_req", imem_req, 0);

`ifndef CTRL_MULDIV_EN
        do_reset();
        fetch(MUL, 0);
        step();
        check("mul_trap", trap, 1);
        check("mul_cause", cause, 0);
`endif

        do_reset();
        fetch(LW, 0);
        step();
        step();
        check("mid_dreq", dmem_req, 1);
        rst = 1'b1;
        #1;
        check("mid_dreq_drop", dmem_req, 0);
        check("mid_pcen", pc_en, 0);
        check("mid_rdwren", rd_wren, 0);
        check("mid_ir", ir, 32'h13);
        check("mid_instret", instret, 0);
        step();
        rst = 1'b0;
        step();
        check("mid_refetch", imem_req, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
